// File: rtl/darkriscv_uart_pkg.sv
// Shared UART definitions for the darkriscv SoC.
// Provides the receiver FSM state type and the common framing constants.
package darkriscv_uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_DIV_115200 = 278;  // 32 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk  - destination clock
//   rst  - synchronous, active-high reset; both flops load RST_VAL
//   d    - asynchronous input
//   q    - synchronized output, two clk edges behind d
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // two stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with a one-entry valid/ready holding register.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous, active-high reset
//   rx        - asynchronous serial input, idle high
//   data      - received byte, stable while valid is high
//   valid     - holding register full
//   ready     - consumer takes data on a cycle with valid && ready
//   frame_err - one-cycle pulse when the stop bit is sampled low
//   overrun   - one-cycle pulse when a byte is dropped because the holding
//               register was full and not being accepted
//   busy      - receiver FSM is not idle
module uart_rx_core
  import darkriscv_uart_pkg::*;
#(
  parameter int DIV = UART_DIV_115200,
  parameter int CW  = $clog2(DIV)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [CW-1:0] HALF_RELOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_RELOAD = CW'(DIV - 1);

  logic                          rx_s;
  uart_rx_state_t                state;
  logic [CW-1:0]                 timer;
  logic [2:0]                    idx;
  logic [UART_DATA_BITS-1:0]     shift;
  logic                          timer_zero;
  logic                          byte_done;

  uart_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign timer_zero = (timer == '0);
  // A good stop bit completes the byte; IDLE is re-entered mid stop bit so
  // the next start edge is caught even with back-to-back frames.
  assign byte_done  = (state == STOP) && timer_zero && rx_s;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      idx       <= '0;
      // NOTE: the shift register is reset as well; it is a handful of flops,
      // not a RAM, and a known value keeps simulation free of X.
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            timer <= HALF_RELOAD;
          end
        end

        START: begin
          if (timer_zero) begin
            if (rx_s) begin
              // Line went back high before mid start bit: treat as glitch.
              state <= IDLE;
            end else begin
              state <= DATA;
              timer <= FULL_RELOAD;
              idx   <= '0;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        DATA: begin
          if (timer_zero) begin
            shift <= {rx_s, shift[UART_DATA_BITS-1:1]};  // LSB first
            timer <= FULL_RELOAD;
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        STOP: begin
          if (timer_zero) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        BREAK: begin
          // Hold here until the line recovers so a long break flags once.
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // Holding register: a same-cycle accept frees the slot for the new byte.
      if (byte_done) begin
        if (!valid || ready) begin
          data  <= shift;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core with DIV = 16.
module tb_uart_rx_core;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         last_e0 = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] value;
    logic       stop_bit;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[5];

  uart_rx_core #(.DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: count error pulses and score every accepted byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got byte 0x%0h, expected none (cycle %0d)", data, cyc);
        end else begin
          check("sb_byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Drives one 8N1 frame; rx is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1 rx = 1'b0;
    last_e0 = cyc + 1;
    repeat (DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (DIV) @(posedge clk);
    end
    #1 rx = stop_bit;
    repeat (DIV) @(posedge clk);
  endtask

  task automatic pulse_ready();
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int f0, o0, guard;

    vecs[0] = '{8'h00, 1'b1, 0};
    vecs[1] = '{8'hFF, 1'b1, 0};
    vecs[2] = '{8'h81, 1'b1, 0};
    vecs[3] = '{8'h5A, 1'b0, 1};
    vecs[4] = '{8'hC4, 1'b1, 0};

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_data", {24'd0, data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ferr", {31'd0, frame_err}, 0);
    check("rst_ovr", {31'd0, overrun}, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // 8'hA5 with ready low, exact completion timing
    f0 = ferr_cnt; o0 = ovr_cnt;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk);
        #2;
        guard = 0;
        while (cyc != last_e0 + 153 && guard < 1000) begin
          @(posedge clk);
          #1;
          guard++;
        end
        check("a5_valid_before", {31'd0, valid}, 0);
        @(posedge clk);
        #1;
        check("a5_valid_at", {31'd0, valid}, 1);
        check("a5_data", {24'd0, data}, 32'hA5);
      end
    join
    check("a5_no_ferr", ferr_cnt - f0, 0);
    check("a5_no_ovr", ovr_cnt - o0, 0);
    exp_q.push_back(8'hA5);
    pulse_ready();
    #2;
    check("a5_valid_drop", {31'd0, valid}, 0);

    // Back-to-back 3C, C3 with ready low: second byte overruns
    o0 = ovr_cnt;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("ovr_data_kept", {24'd0, data}, 32'h3C);
    check("ovr_valid", {31'd0, valid}, 1);
    check("ovr_count", ovr_cnt - o0, 1);
    exp_q.push_back(8'h3C);
    pulse_ready();
    #2;
    check("ovr_valid_drop", {31'd0, valid}, 0);

    // Bad stop bit, then line held low for 40 bit times
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0);
    repeat (40 * DIV) @(posedge clk);
    #1;
    check("brk_busy", {31'd0, busy}, 1);
    check("brk_ferr_once", ferr_cnt - f0, 1);
    check("brk_valid", {31'd0, valid}, 0);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("brk_busy_clear", {31'd0, busy}, 0);

    // 4-cycle glitch
    f0 = ferr_cnt; o0 = ovr_cnt;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    check("glitch_busy", {31'd0, busy}, 1);
    repeat (16) @(posedge clk);
    #1;
    check("glitch_idle", {31'd0, busy}, 0);
    check("glitch_valid", {31'd0, valid}, 0);
    check("glitch_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

    // Table: ready tied high, streamed frames scored by the monitor
    ready = 1'b1;
    o0 = ovr_cnt;
    for (int i = 0; i < 5; i++) begin
      f0 = ferr_cnt;
      if (vecs[i].stop_bit) exp_q.push_back(vecs[i].value);
      send_frame(vecs[i].value, vecs[i].stop_bit);
      #1 rx = 1'b1;
      repeat (4) @(posedge clk);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
    end
    check("stream_no_ovr", ovr_cnt - o0, 0);
    check("stream_drained", exp_q.size(), 0);

    // Reset in the middle of data bit 4
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (DIV * 5 + DIV / 2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_valid", {31'd0, valid}, 0);
    check("midrst_data", {24'd0, data}, 0);
    check("midrst_flags", {30'd0, frame_err, overrun}, 0);
    rst = 1'b0;
    rx = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_data", {24'd0, data}, 32'h7E);
    check("post_rst_drained", exp_q.size(), 0);
    check("post_rst_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
